msg_scroller: RTL

MSG_SCROLLER -- requirements
Module: msg_scroller

---
 rtl/msg_scroller.sv | 139 +++++++++++++
 1 files changed

// File: rtl/msg_scroller.sv
// Scrolling message display: buffers up to MAX_LEN 4-bit codes and slides
// them across NUM_DIGITS positions, one step every TICK_DIV clocks.
module msg_scroller #(
  parameter int NUM_DIGITS = 6,
  parameter int MAX_LEN    = 16,
  parameter int TICK_DIV   = 12_500_000
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        wr_en,
  input  logic [3:0]                  wr_char,
  input  logic                        clear,
  input  logic                        start,
  input  logic                        stop,
  input  logic                        loop_en,
  output logic                        busy,
  output logic                        done,
  output logic                        overflow,
  output logic [$clog2(MAX_LEN):0]    msg_len,
  output logic [4*NUM_DIGITS-1:0]     digit_codes,
  output logic [NUM_DIGITS-1:0]       digit_blank
);

  localparam int LW = $clog2(MAX_LEN) + 1;
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int PW = $clog2(MAX_LEN + NUM_DIGITS) + 1;
  localparam int TW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    IDLE,
    SCROLL,
    DONE
  } state_t;

  state_t          state_q, state_n;
  logic [PW-1:0]   pos_q, pos_n;
  logic [TW-1:0]   tick_q, tick_n;
  logic [LW-1:0]   len_q;
  logic            ovf_q;
  logic [3:0]      mem_q [MAX_LEN];

  logic            go, full, step, last;
  logic            wr_ok, wr_drop;
  logic [PW-1:0]   rel [NUM_DIGITS];
  logic [4*NUM_DIGITS-1:0] codes_n;
  logic [NUM_DIGITS-1:0]   blank_n;

  assign msg_len  = len_q;
  assign overflow = ovf_q;

  assign go      = (state_q == IDLE) && start && (len_q != '0);
  assign full    = len_q == LW'(MAX_LEN);
  assign step    = tick_q == TW'(TICK_DIV - 1);
  assign last    = pos_q == PW'(len_q) + PW'(NUM_DIGITS - 1);
  assign wr_ok   = (state_q == IDLE) && !go && !clear && wr_en && !full;
  assign wr_drop = (state_q == IDLE) && !go && !clear && wr_en && full;

  always_comb begin
    state_n = state_q;
    pos_n   = pos_q;
    tick_n  = tick_q;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          state_n = SCROLL;
          pos_n   = '0;
          tick_n  = '0;
        end
      end
      SCROLL: begin
        if (stop) begin
          state_n = IDLE;
        end else if (step) begin
          tick_n = '0;
          if (!last) begin
            pos_n = pos_q + PW'(1);
          end else if (loop_en) begin
            pos_n = '0;
          end else begin
            state_n = DONE;
          end
        end else begin
          tick_n = tick_q + TW'(1);
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Window is built from the next pos so digits line up with busy.
  always_comb begin
    codes_n = '0;
    blank_n = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      rel[i] = pos_n - PW'(i);
      if (state_n == SCROLL && pos_n >= PW'(i) &&
          rel[i] < PW'(len_q)) begin
        codes_n[4*i +: 4] = mem_q[rel[i][AW-1:0]];
        blank_n[i]        = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      pos_q       <= '0;
      tick_q      <= '0;
      len_q       <= '0;
      ovf_q       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      digit_codes <= '0;
      digit_blank <= '1;
    end else begin
      state_q     <= state_n;
      pos_q       <= pos_n;
      tick_q      <= tick_n;
      busy        <= state_n == SCROLL;
      done        <= state_n == DONE;
      digit_codes <= codes_n;
      digit_blank <= blank_n;
      if (state_q == IDLE && !go && clear) begin
        len_q <= '0;
        ovf_q <= 1'b0;
      end else if (wr_ok) begin
        len_q <= len_q + LW'(1);
      end else if (wr_drop) begin
        ovf_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[len_q[AW-1:0]] <= wr_char;
  end

endmodule
